// File: rtl/mem_arb_pkg.sv
// Shared definitions for mem_rr_arbiter: FSM state encoding, default RAM
// widths and a one-hot to index helper used when recording the last grant.
package mem_arb_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int unsigned DEF_AW    = 8;
  localparam int unsigned DEF_DW    = 8;
  localparam int unsigned MAX_CORES = 8;

  // OR-reduction form: for a one-hot input this is the set bit's index, for
  // zero it is 0. No priority chain is built.
  function automatic logic [2:0] onehot_to_idx(input logic [MAX_CORES-1:0] oh);
    logic [2:0] idx;
    idx = '0;
    for (int i = 0; i < int'(MAX_CORES); i++) begin
      if (oh[i]) idx = idx | 3'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/mem_rr_arbiter_if.sv
// Bundle of the per-core request/grant bus and the single-port RAM port
// that mem_rr_arbiter sits between.
interface mem_rr_arbiter_if #(
  parameter int unsigned NCORES = 3,
  parameter int unsigned AW     = mem_arb_pkg::DEF_AW,
  parameter int unsigned DW     = mem_arb_pkg::DEF_DW
);
  import mem_arb_pkg::*;

  // Handshake: core i raises req[i] and holds it (with stable addr/wren/din
  // for the access it wants) until done. Every cycle in which req[i] and
  // gnt[i] are both high is exactly one RAM access; a read's data comes back
  // one cycle later as rvalid[i] with dq. Dropping req[i] ends the grant.
  logic [NCORES-1:0]    req;
  logic [NCORES-1:0]    wren;
  logic [NCORES*AW-1:0] addr;
  logic [NCORES*DW-1:0] din;
  logic [NCORES-1:0]    gnt;
  logic [NCORES-1:0]    rvalid;
  logic [DW-1:0]        dq;

  logic [AW-1:0]        ram_addr;
  logic [DW-1:0]        ram_din;
  logic                 ram_wren;
  logic [DW-1:0]        ram_q;

  state_t               dbg_state;

  modport master (
    output req, wren, addr, din, ram_q,
    input  gnt, rvalid, dq, ram_addr, ram_din, ram_wren, dbg_state
  );

  modport slave (
    input  req, wren, addr, din, ram_q,
    output gnt, rvalid, dq, ram_addr, ram_din, ram_wren, dbg_state
  );

endinterface

// File: rtl/mem_rr_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester found searching
// last+1, last+2, ... with wrap-around.
module rr_pick #(
  parameter int N  = 3,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  pick_o,
  output logic          valid_o
);

  logic [IW-1:0] idx;

  always_comb begin
    pick_o  = '0;
    valid_o = 1'b0;
    idx     = '0;
    // k runs to N so the previous winner is considered last.
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last_i) + k) % N);
      if (!valid_o && req_i[idx]) begin
        pick_o[idx] = 1'b1;
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between
// NCORES cores. Define ARB_TIMEOUT_EN to bound a grant to MAX_HOLD accesses.
module mem_rr_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned NCORES   = 3,
  parameter int unsigned AW       = DEF_AW,
  parameter int unsigned DW       = DEF_DW
`ifdef ARB_TIMEOUT_EN
  , parameter int unsigned MAX_HOLD = 4
`endif
) (
  input  logic            clk,
  input  logic            rst,
  mem_rr_arbiter_if.slave bus
);

  localparam int IW = $clog2(NCORES);

  state_t            state_q;
  logic [NCORES-1:0] gnt_q;
  logic [NCORES-1:0] rvalid_q;
  logic [IW-1:0]     last_q;

  logic [NCORES-1:0] pick;
  logic              pick_valid;
  logic [IW-1:0]     pick_idx;
  logic              access;
  logic              sel_wren;

`ifdef ARB_TIMEOUT_EN
  localparam int HW = $clog2(MAX_HOLD + 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

  logic [HW-1:0] hold_q;
  logic          others_waiting;

  assign others_waiting = (bus.req & ~gnt_q) != '0;
`endif

  rr_pick #(
    .N  (NCORES),
    .IW (IW)
  ) u_rr_pick (
    .req_i   (bus.req),
    .last_i  (last_q),
    .pick_o  (pick),
    .valid_o (pick_valid)
  );

  assign pick_idx = IW'(onehot_to_idx(MAX_CORES'(pick)));
  assign access   = (state_q == ST_GRANT) && ((bus.req & gnt_q) != '0);
  assign sel_wren = (bus.wren & gnt_q) != '0;

  // RAM port follows the granted core; the write strobe is also blocked in
  // the reset cycle so an access cut by reset never lands in the RAM.
  always_comb begin
    bus.ram_addr = '0;
    bus.ram_din  = '0;
    if (state_q == ST_GRANT) begin
      for (int i = 0; i < int'(NCORES); i++) begin
        if (gnt_q[i]) begin
          bus.ram_addr = bus.addr[i*AW +: AW];
          bus.ram_din  = bus.din[i*DW +: DW];
        end
      end
    end
    bus.ram_wren = access && sel_wren && !rst;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      gnt_q    <= '0;
      rvalid_q <= '0;
      last_q   <= IW'(NCORES - 1);
`ifdef ARB_TIMEOUT_EN
      hold_q   <= '0;
`endif
    end else begin
      // Read data comes back one cycle later, even if the grant drops meanwhile.
      rvalid_q <= (access && !sel_wren) ? gnt_q : '0;
      case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt_q   <= pick;
            last_q  <= pick_idx;
            state_q <= ST_GRANT;
`ifdef ARB_TIMEOUT_EN
            hold_q  <= '0;
`endif
          end
        end
        ST_GRANT: begin
          if (!access) begin
            gnt_q   <= '0;
            state_q <= ST_IDLE;
          end
`ifdef ARB_TIMEOUT_EN
          else if (hold_q == HOLD_LAST && others_waiting) begin
            gnt_q   <= '0;
            state_q <= ST_IDLE;
          end else if (hold_q != HOLD_LAST) begin
            hold_q  <= hold_q + HW'(1);
          end
`endif
        end
        default: begin
          gnt_q   <= '0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.rvalid    = rvalid_q;
  assign bus.dq        = bus.ram_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter (NCORES=3, AW=8, DW=8, MAX_HOLD=4): cycle table
// plus timeout and reset-mid-write sequences; read data via a scoreboard.
module tb_mem_rr_arbiter;
  import mem_arb_pkg::*;

  localparam int NC = 3;
  localparam int AW = 8;
  localparam int DW = 8;

  typedef struct packed {
    logic             rst;
    logic [NC-1:0]    req;
    logic [NC-1:0]    wren;
    logic [NC*AW-1:0] addr;
    logic [NC*DW-1:0] din;
    logic [NC-1:0]    gnt;   // expected registered grant this cycle
    logic             acc;   // expected RAM access this cycle
  } row_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ram_clr = 1'b1;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  mem_rr_arbiter_if #(.NCORES(NC), .AW(AW), .DW(DW)) bus ();

  mem_rr_arbiter #(.NCORES(NC), .AW(AW), .DW(DW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // RAM model: unwritten locations read as addr ^ 8'hA5.
  logic [DW-1:0] ram_mem [0:255];
  logic [255:0]  ram_vld;
  always @(posedge clk) begin
    if (ram_clr) ram_vld <= '0;
    else if (bus.ram_wren) begin
      ram_mem[bus.ram_addr] <= bus.ram_din;
      ram_vld[bus.ram_addr] <= 1'b1;
    end
    bus.ram_q <= (!ram_clr && ram_vld[bus.ram_addr]) ? ram_mem[bus.ram_addr]
                                                      : (bus.ram_addr ^ 8'hA5);
  end

  // scoreboard: {rvalid mask, dq} expected one cycle after each read access
  logic [NC+DW-1:0] exp_q[$];
  logic [DW-1:0]    sh_mem [0:255];
  bit   [255:0]     sh_vld;

  function automatic logic [DW-1:0] exp_data(input logic [AW-1:0] a);
    return sh_vld[a] ? sh_mem[a] : (a ^ 8'hA5);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  function automatic row_t mk(input logic r, input logic [NC-1:0] rq, input logic [NC-1:0] we,
                              input logic [NC*AW-1:0] a, input logic [NC*DW-1:0] d,
                              input logic [NC-1:0] g, input logic ac);
    row_t x;
    x.rst = r; x.req = rq; x.wren = we; x.addr = a; x.din = d; x.gnt = g; x.acc = ac;
    return x;
  endfunction

  // driver + checker for one cycle
  task automatic apply_row(input row_t r, input string tag);
    logic [AW-1:0]    e_addr;
    logic [DW-1:0]    e_din;
    logic             e_wr;
    logic [NC+DW-1:0] e;
    @(negedge clk);
    rst      = r.rst;
    bus.req  = r.req;
    bus.wren = r.wren;
    bus.addr = r.addr;
    bus.din  = r.din;
    #1;
    e_addr = '0;
    e_din  = '0;
    e_wr   = 1'b0;
    for (int i = 0; i < NC; i++) begin
      if (r.gnt[i]) begin
        e_addr = r.addr[i*AW +: AW];
        e_din  = r.din[i*DW +: DW];
        e_wr   = r.wren[i];
      end
    end
    e_wr = e_wr & r.acc;
    chk($sformatf("%s gnt", tag), 32'(bus.gnt), 32'(r.gnt));
    chk($sformatf("%s state", tag), 32'(bus.dbg_state),
        (r.gnt != '0) ? 32'(ST_GRANT) : 32'(ST_IDLE));
    chk($sformatf("%s ram_wren", tag), 32'(bus.ram_wren), 32'(e_wr));
    if (r.acc) chk($sformatf("%s ram_addr", tag), 32'(bus.ram_addr), 32'(e_addr));
    if (e_wr)  chk($sformatf("%s ram_din", tag), 32'(bus.ram_din), 32'(e_din));
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk($sformatf("%s rvalid", tag), 32'(bus.rvalid), 32'(e[NC+DW-1:DW]));
      chk($sformatf("%s dq", tag), 32'(bus.dq), 32'(e[DW-1:0]));
    end else begin
      chk($sformatf("%s rvalid", tag), 32'(bus.rvalid), 32'(0));
    end
    if (r.acc && !e_wr) exp_q.push_back({r.gnt, exp_data(e_addr)});
    if (e_wr) begin
      sh_mem[e_addr] = e_din;
      sh_vld[e_addr] = 1'b1;
    end
  endtask

  row_t tbl[$];
  row_t seq_to[$];
  row_t seq_rst[$];

  initial begin
    logic [NC*AW-1:0] ad, ad4, ad5, ad6;
    logic [NC*DW-1:0] dd, dd4, dd6, dd6e;
    ad   = {8'h30, 8'h10, 8'h20};
    dd   = {8'hC3, 8'h5A, 8'h11};
    ad4  = {8'h31, 8'h10, 8'h20};
    dd4  = {8'h3C, 8'h5A, 8'h11};
    ad5  = {8'h30, 8'h40, 8'h20};
    ad6  = {8'h30, 8'h10, 8'h50};
    dd6  = {8'hC3, 8'h5A, 8'h77};
    dd6e = {8'hC3, 8'h5A, 8'hEE};

    // reset with all requesting, then first grant goes to core 0
    tbl.push_back(mk(1, 3'b111, 3'b000, ad, dd, 3'b000, 0));
    tbl.push_back(mk(1, 3'b111, 3'b000, ad, dd, 3'b000, 0));
    tbl.push_back(mk(0, 3'b111, 3'b000, ad, dd, 3'b000, 0));
    tbl.push_back(mk(0, 3'b000, 3'b000, ad, dd, 3'b001, 0));
    tbl.push_back(mk(0, 3'b000, 3'b000, ad, dd, 3'b000, 0));
    // core1 writes 0x5A to 0x10 then reads it back
    tbl.push_back(mk(0, 3'b010, 3'b010, ad, dd, 3'b000, 0));
    tbl.push_back(mk(0, 3'b010, 3'b010, ad, dd, 3'b010, 1));
    tbl.push_back(mk(0, 3'b010, 3'b000, ad, dd, 3'b010, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, ad, dd, 3'b010, 0));
    // re-reset so core0 again has first priority
    tbl.push_back(mk(1, 3'b000, 3'b000, ad, dd, 3'b000, 0));
    // fairness: all request, each releases after one read
    tbl.push_back(mk(0, 3'b111, 3'b000, ad, dd, 3'b000, 0));
    tbl.push_back(mk(0, 3'b111, 3'b000, ad, dd, 3'b001, 1));
    tbl.push_back(mk(0, 3'b110, 3'b000, ad, dd, 3'b001, 0));
    tbl.push_back(mk(0, 3'b111, 3'b000, ad, dd, 3'b000, 0));
    tbl.push_back(mk(0, 3'b111, 3'b000, ad, dd, 3'b010, 1));
    tbl.push_back(mk(0, 3'b101, 3'b000, ad, dd, 3'b010, 0));
    tbl.push_back(mk(0, 3'b111, 3'b000, ad, dd, 3'b000, 0));
    tbl.push_back(mk(0, 3'b111, 3'b000, ad, dd, 3'b100, 1));
    tbl.push_back(mk(0, 3'b011, 3'b000, ad, dd, 3'b100, 0));
    tbl.push_back(mk(0, 3'b111, 3'b000, ad, dd, 3'b000, 0));
    tbl.push_back(mk(0, 3'b111, 3'b000, ad, dd, 3'b001, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, ad, dd, 3'b001, 0));
    tbl.push_back(mk(0, 3'b000, 3'b000, ad, dd, 3'b000, 0));
    // contention: core2 bursting, core0 arrives mid-burst and waits
    tbl.push_back(mk(0, 3'b100, 3'b100, ad,  dd,  3'b000, 0));
    tbl.push_back(mk(0, 3'b100, 3'b100, ad,  dd,  3'b100, 1));
    tbl.push_back(mk(0, 3'b101, 3'b100, ad4, dd4, 3'b100, 1));
    tbl.push_back(mk(0, 3'b101, 3'b000, ad,  dd,  3'b100, 1));
    tbl.push_back(mk(0, 3'b001, 3'b000, ad,  dd,  3'b100, 0));
    tbl.push_back(mk(0, 3'b001, 3'b000, ad,  dd,  3'b000, 0));
    tbl.push_back(mk(0, 3'b001, 3'b000, ad,  dd,  3'b001, 1));
    tbl.push_back(mk(0, 3'b000, 3'b000, ad,  dd,  3'b001, 0));
    tbl.push_back(mk(0, 3'b000, 3'b000, ad,  dd,  3'b000, 0));

    // core0 holds req 10 cycles, core1 joins one cycle later
    seq_to.push_back(mk(0, 3'b001, 3'b000, ad5, dd, 3'b000, 0));
`ifdef ARB_TIMEOUT_EN
    for (int i = 0; i < 4; i++) seq_to.push_back(mk(0, 3'b011, 3'b000, ad5, dd, 3'b001, 1));
    seq_to.push_back(mk(0, 3'b011, 3'b000, ad5, dd, 3'b000, 0));
    seq_to.push_back(mk(0, 3'b011, 3'b000, ad5, dd, 3'b010, 1));
    seq_to.push_back(mk(0, 3'b001, 3'b000, ad5, dd, 3'b010, 0));
    seq_to.push_back(mk(0, 3'b001, 3'b000, ad5, dd, 3'b000, 0));
    seq_to.push_back(mk(0, 3'b001, 3'b000, ad5, dd, 3'b001, 1));
    seq_to.push_back(mk(0, 3'b000, 3'b000, ad5, dd, 3'b001, 0));
    seq_to.push_back(mk(0, 3'b000, 3'b000, ad5, dd, 3'b000, 0));
`else
    for (int i = 0; i < 9; i++) seq_to.push_back(mk(0, 3'b011, 3'b000, ad5, dd, 3'b001, 1));
    seq_to.push_back(mk(0, 3'b010, 3'b000, ad5, dd, 3'b001, 0));
    seq_to.push_back(mk(0, 3'b010, 3'b000, ad5, dd, 3'b000, 0));
    seq_to.push_back(mk(0, 3'b010, 3'b000, ad5, dd, 3'b010, 1));
    seq_to.push_back(mk(0, 3'b000, 3'b000, ad5, dd, 3'b010, 0));
    seq_to.push_back(mk(0, 3'b000, 3'b000, ad5, dd, 3'b000, 0));
`endif

    // reset during core0's write: the reset-cycle write (0xEE) must not land
    seq_rst.push_back(mk(0, 3'b001, 3'b001, ad6, dd6,  3'b000, 0));
    seq_rst.push_back(mk(0, 3'b001, 3'b001, ad6, dd6,  3'b001, 1));
    seq_rst.push_back(mk(1, 3'b001, 3'b001, ad6, dd6e, 3'b001, 0));
    seq_rst.push_back(mk(0, 3'b001, 3'b000, ad6, dd6,  3'b000, 0));
    seq_rst.push_back(mk(0, 3'b001, 3'b000, ad6, dd6,  3'b001, 1));
    seq_rst.push_back(mk(0, 3'b000, 3'b000, ad6, dd6,  3'b001, 0));
    seq_rst.push_back(mk(0, 3'b000, 3'b000, ad6, dd6,  3'b000, 0));

    bus.req  = '0;
    bus.wren = '0;
    bus.addr = '0;
    bus.din  = '0;
    rst      = 1'b1;
    @(posedge clk);
    #1;
    ram_clr = 1'b0;

    foreach (tbl[i])     apply_row(tbl[i],     $sformatf("tbl%0d", i));
    foreach (seq_to[i])  apply_row(seq_to[i],  $sformatf("timeout%0d", i));
    foreach (seq_rst[i]) apply_row(seq_rst[i], $sformatf("rstwr%0d", i));

    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_drain: got %0d pending want 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
